// File: rtl/sclk_pkg.sv
// Shared types and default widths for the sclk burst generator.
package sclk_pkg;
   localparam int DIV_W_DEF = 16;
   localparam int CNT_W_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/sclk_div_cnt.sv
// Half-period down-counter: load has priority, decrement stops at zero.
// zero_o is registered-state derived, so it marks the last cycle of each half-period.
module sclk_div_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/sclk_burst_gen.sv
// Generates a burst of npulses sclk periods (2*div clk cycles each) with edge strobes.
// First leading edge appears div+1 cycles after start; done coincides with the final trailing edge.
module sclk_burst_gen
   import sclk_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] npulses,
   input  logic             cpol,
   output logic             sclk,
   output logic             lead_stb,
   output logic             trail_stb,
   output logic             busy,
   output logic             done
);
   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] npulses_q, npulses_d;
   logic             cpol_q, cpol_d;
   logic [CNT_W:0]   edge_q, edge_d, edge_nxt;
   logic             sclk_q, sclk_d;
   logic             lead_q, lead_d;
   logic             trail_q, trail_d;
   logic             done_q, done_d;
   logic             accept, last_edge;
   logic             cnt_load, cnt_zero;
   logic [DIV_W-1:0] cnt_val;

   assign accept    = start && (div != '0) && (npulses != '0);
   assign edge_nxt  = edge_q + (CNT_W+1)'(1);
   assign last_edge = (edge_nxt == {npulses_q, 1'b0});

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      npulses_d = npulses_q;
      cpol_d    = cpol_q;
      edge_d    = edge_q;
      sclk_d    = sclk_q;
      lead_d    = 1'b0;
      trail_d   = 1'b0;
      done_d    = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = div_q - DIV_W'(1);
      case (state_q)
         IDLE: begin
            sclk_d = cpol_q;
            if (accept) begin
               state_d   = RUN;
               div_d     = div;
               npulses_d = npulses;
               cpol_d    = cpol;
               sclk_d    = cpol;
               edge_d    = '0;
               cnt_load  = 1'b1;
               cnt_val   = div - DIV_W'(1);
            end
         end
         RUN: begin
            // Abort wins over a toggle due in the same cycle, so no strobe escapes.
            if (abort) begin
               state_d = IDLE;
               sclk_d  = cpol_q;
            end else if (cnt_zero) begin
               cnt_load = 1'b1;
               edge_d   = edge_nxt;
               if (last_edge) begin
                  state_d = IDLE;
                  sclk_d  = cpol_q;
                  trail_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  sclk_d  = ~sclk_q;
                  lead_d  = (sclk_q == cpol_q);
                  trail_d = (sclk_q != cpol_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         npulses_q <= '0;
         cpol_q    <= 1'b0;
         edge_q    <= '0;
         sclk_q    <= 1'b0;
         lead_q    <= 1'b0;
         trail_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         npulses_q <= npulses_d;
         cpol_q    <= cpol_d;
         edge_q    <= edge_d;
         sclk_q    <= sclk_d;
         lead_q    <= lead_d;
         trail_q   <= trail_d;
         done_q    <= done_d;
      end
   end

   sclk_div_cnt #(.W(DIV_W)) u_div_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .en_i       (state_q == RUN),
      .zero_o     (cnt_zero)
   );

   assign sclk      = sclk_q;
   assign lead_stb  = lead_q;
   assign trail_stb = trail_q;
   assign done      = done_q;
   assign busy      = (state_q == RUN);
endmodule

// File: tb/tb_sclk_burst_gen.sv
// Scoreboarded bench: stimulus queues expected output events, a negedge monitor matches them.
`timescale 1ns/1ps
module tb_sclk_burst_gen;
   localparam int EV_RISE  = 0;
   localparam int EV_LEAD  = 1;
   localparam int EV_TRAIL = 2;
   localparam int EV_DONE  = 3;
   localparam int EV_FALL  = 4;

   typedef struct {
      int   cyc;
      int   kind;
      logic sclk;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] div = '0;
   logic [7:0]  npulses = '0;
   logic        cpol = 1'b0;
   logic        sclk, lead_stb, trail_stb, busy, done;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   logic busy_prev = 1'b0;
   ev_t  exp_q[$];

   sclk_burst_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .div       (div),
      .npulses   (npulses),
      .cpol      (cpol),
      .sclk      (sclk),
      .lead_stb  (lead_stb),
      .trail_stb (trail_stb),
      .busy      (busy),
      .done      (done)
   );

   always #5.556 clk = ~clk;   // ~90 MHz
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input int k, input logic s);
      ev_t e;
      e.cyc = c; e.kind = k; e.sclk = s;
      exp_q.push_back(e);
   endtask

   task automatic expect_burst(input int t, input int d, input int n, input logic cp);
      push(t + 1, EV_RISE, cp);
      for (int k = 1; k <= 2 * n; k++) begin
         if (k % 2 == 1) begin
            push(t + 1 + k * d, EV_LEAD, ~cp);
         end else begin
            push(t + 1 + k * d, EV_TRAIL, cp);
            if (k == 2 * n) begin
               push(t + 1 + k * d, EV_DONE, cp);
               push(t + 1 + k * d, EV_FALL, cp);
            end
         end
      end
   endtask

   task automatic check_evt(input int kind);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL event: got unexpected kind=%0d at cyc=%0d sclk=%0b, required none", kind, cyc, sclk);
      end else begin
         e = exp_q.pop_front();
         if (e.cyc != cyc || e.kind != kind || e.sclk !== sclk) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d sclk=%0b, required kind=%0d cyc=%0d sclk=%0b",
                     kind, cyc, sclk, e.kind, e.cyc, e.sclk);
         end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // Monitor: flags expected events whose cycle passed, then matches every observed event.
   always @(negedge clk) begin
      if (mon_en) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: got nothing by cyc=%0d, required kind=%0d at cyc=%0d",
                     cyc, exp_q[0].kind, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (busy && !busy_prev) check_evt(EV_RISE);
         if (lead_stb)           check_evt(EV_LEAD);
         if (trail_stb)          check_evt(EV_TRAIL);
         if (done)               check_evt(EV_DONE);
         if (!busy && busy_prev) check_evt(EV_FALL);
         busy_prev = busy;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int d, input int n, input logic cp, output int t);
      tick();
      t = cyc;
      div = 16'(d); npulses = 8'(n); cpol = cp; start = 1'b1;
   endtask

   initial begin
      int t;
      // Reset state
      repeat (3) tick();
      @(negedge clk);
      chk("rst_sclk", 32'(sclk), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_lead", 32'(lead_stb), 0);
      chk("rst_trail", 32'(trail_stb), 0);
      tick();
      rst_n = 1'b1;
      mon_en = 1'b1;

      // div=5, npulses=4, cpol=0: 10-cycle period, done at T+41
      launch(5, 4, 1'b0, t);
      expect_burst(t, 5, 4, 1'b0);
      tick(); start = 1'b0;
      repeat (45) tick();
      @(negedge clk);
      chk("idle_sclk_cpol0", 32'(sclk), 0);

      // div=1, npulses=1, cpol=1: low at T+2, high and done at T+3
      launch(1, 1, 1'b1, t);
      expect_burst(t, 1, 1, 1'b1);
      tick(); start = 1'b0;
      repeat (6) tick();
      @(negedge clk);
      chk("idle_sclk_cpol1", 32'(sclk), 1);

      // start held across done: second burst starts with no gap; input changes in RUN ignored
      launch(2, 2, 1'b0, t);
      expect_burst(t, 2, 2, 1'b0);
      expect_burst(t + 9, 2, 2, 1'b0);
      repeat (10) tick();
      start = 1'b0; div = 16'd7; npulses = 8'd9; cpol = 1'b1;
      repeat (12) tick();
      @(negedge clk);
      chk("idle_sclk_captured", 32'(sclk), 0);
      chk("b2b_idle_busy", 32'(busy), 0);

      // Illegal starts and a lone abort in IDLE produce nothing
      launch(0, 3, 1'b1, t);
      tick(); div = 16'd3; npulses = 8'd0;
      tick(); start = 1'b0; abort = 1'b1; div = 16'd4; npulses = 8'd2;
      tick(); abort = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      chk("ignored_busy", 32'(busy), 0);
      chk("ignored_sclk", 32'(sclk), 0);

      // Abort at T+13 (sclk already back at cpol)
      launch(5, 4, 1'b1, t);
      push(t + 1, EV_RISE, 1'b1);
      push(t + 6, EV_LEAD, 1'b0);
      push(t + 11, EV_TRAIL, 1'b1);
      push(t + 14, EV_FALL, 1'b1);
      tick(); start = 1'b0;
      repeat (12) tick();
      abort = 1'b1;
      tick(); abort = 1'b0;
      repeat (40) tick();

      // Start+abort together in IDLE starts; abort at T+8 while sclk is away from cpol
      launch(5, 4, 1'b0, t);
      abort = 1'b1;
      push(t + 1, EV_RISE, 1'b0);
      push(t + 6, EV_LEAD, 1'b1);
      push(t + 9, EV_FALL, 1'b0);
      tick(); start = 1'b0; abort = 1'b0;
      repeat (7) tick();
      abort = 1'b1;
      tick(); abort = 1'b0;
      @(negedge clk);
      chk("abort_sclk", 32'(sclk), 0);
      repeat (40) tick();

      // Reset for one cycle mid-burst with cpol=1: sclk drops to reset value 0
      launch(5, 4, 1'b1, t);
      push(t + 1, EV_RISE, 1'b1);
      push(t + 6, EV_LEAD, 1'b0);
      push(t + 9, EV_FALL, 1'b0);
      tick(); start = 1'b0;
      repeat (7) tick();
      rst_n = 1'b0;
      tick(); rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_sclk", 32'(sclk), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_lead", 32'(lead_stb), 0);
      chk("midrst_trail", 32'(trail_stb), 0);
      repeat (45) tick();

      @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200us, required finish");
      $fatal(1);
   end
endmodule
